cksum_ctrl: RTL and testbench
=============================

// Module: cksum_ctrl
// PURPOSE
//  Sequencer in front of the cksum engine. Takes a verify/update request for a header region in packet memory and drives
//  the engine's start handshake. Shares the engine's memory read port. Verify: reports pass/fail. Update: zeroes the
//  checksum field, recomputes it and writes the result back to memory.
// PARAMETERS
//  ADDR_WIDTH  32    byte-address width of packet memory
//  DATA_WIDTH  32    memory word width; fixed at 32 (two 16-bit halves)
//  TIMEOUT     1024  max cycles in WAIT before abort
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  req_valid_i     in   1   request valid
//  req_ready_o     out  1   high only in IDLE; request accepted when valid&ready
//  req_op_i        in   1   0 = verify, 1 = update
//  req_start_i     in   AW  region start byte address (2-byte aligned)
//  req_len_i       in   DW  region length in bytes (even, nonzero)
//  req_field_i     in   AW  byte address of 16-bit checksum field (2-byte aligned, inside region)
//  mem_addr_o      out  AW  memory address; read data returns next cycle
//  mem_rdata_i     in   DW  memory read data
//  mem_we_o        out  1   memory write strobe
//  mem_be_o        out  4   byte enables: [3:2] = half at addr%4==0, [1:0] = half at addr%4==2
//  mem_wdata_o     out  DW  write data, 16-bit value replicated in both halves
//  eng_start_o     out  1   engine start (level, held until engine ready)
//  eng_saddr_o     out  AW  engine field_start_addr
//  eng_len_o       out  DW  engine field_len
//  eng_addr_i      in   AW  engine memory address
//  eng_ready_i     in   1   engine result valid
//  eng_val_i       in   16  engine result (complemented folded sum)
//  done_o          out  1   one-cycle pulse: request finished
//  ok_o            out  1   valid with done_o: verify passed / update written
//  err_o           out  1   valid with done_o: bad request or timeout
//  result_o        out  16  valid with done_o: engine value (0 on error)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1. Reset mid-request aborts, no further memory write, start low.
//  Request fields are latched on acceptance and are don't-care afterwards.
//  FSM: IDLE -> CHECK -> [CLEAR] -> START -> WAIT -> [WRITE] -> DONE -> IDLE.
//   CHECK: len==0, len odd, start odd, field odd, or field outside [start, start+len-2] -> DONE with err=1, no mem access.
//          Otherwise update -> CLEAR, verify -> START.
//   CLEAR (1 cycle): mem_we=1, addr=field&~3, wdata=0, be = field[1] ? 4'b0011 : 4'b1100.
//   START (1 cycle): eng_start_o=1; engine in FREE latches at this edge and clears its ready.
//   WAIT: eng_start_o=1; mem_addr_o=eng_addr_i; timeout counter increments.
//         eng_ready_i=1 -> latch eng_val_i; update -> WRITE, verify -> DONE.
//         Counter reaches TIMEOUT-1 -> DONE with err=1, start dropped.
//   WRITE (1 cycle): start low, mem_we=1, addr=field&~3, wdata={val,val}, be as CLEAR.
//   DONE (1 cycle): done_o=1, start low; verify ok = (val==16'h0000); update ok=1; err -> ok=0.
//  Outside WAIT: mem_addr_o = controller address (field&~3 in CLEAR/WRITE, else 0).
//  eng_start_o is always low in CHECK/WRITE/DONE/IDLE, so the engine always returns to FREE before the next START.
//  mem_we_o is high only in CLEAR and WRITE; never in verify.
//  Latency: verify = 4 + engine cycles; update = 6 + engine cycles (accept to done_o).
//  req_valid_i outside IDLE is ignored (ready=0); back-to-back requests are accepted the cycle after DONE.
// TESTING
//  1 Update: IPv4 hdr 4500 0073 0000 4000 4011 0000 c0a8 0001 c0a8 00c7 at 0x100, len 20, field 0x10A
//    -> CLEAR write be=0011 @0x108; WRITE wdata=0xB861B861 be=0011 @0x108; done, ok=1, result=0xB861.
//  2 Verify the same header afterwards -> no mem_we; done, ok=1, result=0x0000.
//  3 Verify with byte 0x10C changed to 0xC1 -> ok=0, err=0, result!=0.
//  4 len=19, len=0, or field=0x200 outside region -> done 2 cycles after accept, err=1, no eng_start, no write.
//  5 Stub engine never asserts ready, TIMEOUT=16 -> done with err=1 after 16 WAIT cycles; start low; no write.
//  6 rst pulsed in WAIT during update -> IDLE, req_ready=1, eng_start=0, no WRITE; new verify then completes correctly.

Source files
------------

// File: rtl/cksum_ctrl.sv
// Request sequencer for the checksum engine: validates a header region, optionally
// clears the checksum field, runs the engine over the shared read port and writes back.
module cksum_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_start_i,
  input  logic [DATA_WIDTH-1:0] req_len_i,
  input  logic [ADDR_WIDTH-1:0] req_field_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  eng_start_o,
  output logic [ADDR_WIDTH-1:0] eng_saddr_o,
  output logic [DATA_WIDTH-1:0] eng_len_o,
  input  logic [ADDR_WIDTH-1:0] eng_addr_i,
  input  logic                  eng_ready_i,
  input  logic [15:0]           eng_val_i,
  output logic                  done_o,
  output logic                  ok_o,
  output logic                  err_o,
  output logic [15:0]           result_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam int XW = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]            state_q, state_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] field_q, field_d;
  logic [15:0]           val_q, val_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [XW-1:0]         startX, fieldX, lastX;
  logic                  badReq;
  logic [ADDR_WIDTH-1:0] fieldWord;
  logic [3:0]            halfBe;
  logic                  writing;
  logic                  unused_rdata;

  // The read port is consumed by the engine; the controller never reads memory itself.
  assign unused_rdata = ^mem_rdata_i;

  // Range math is one bit wider than the widest operand so start+len cannot wrap.
  assign startX = XW'(start_q);
  assign fieldX = XW'(field_q);
  assign lastX  = startX + XW'(len_q) - XW'(2);

  assign badReq = (len_q == '0) || len_q[0] || start_q[0] || field_q[0] ||
                  (fieldX < startX) || (fieldX > lastX);

  assign fieldWord = {field_q[ADDR_WIDTH-1:2], 2'b00};
  assign halfBe    = field_q[1] ? 4'b0011 : 4'b1100;
  assign writing   = (state_q == CLEAR) || (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    start_d = start_q;
    len_d   = len_q;
    field_d = field_q;
    val_d   = val_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          start_d = req_start_i;
          len_d   = req_len_i;
          field_d = req_field_i;
          val_d   = 16'h0000;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (badReq) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = op_q ? CLEAR : START;
        end
      end
      CLEAR: state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_ready_i) begin
          val_d   = eng_val_i;
          state_d = op_q ? WRITE : DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      field_q <= '0;
      val_q   <= 16'h0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      start_q <= start_d;
      len_q   <= len_d;
      field_q <= field_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory port is handed to the engine only while it is running.
  assign mem_addr_o  = (state_q == WAIT) ? eng_addr_i : (writing ? fieldWord : '0);
  assign mem_we_o    = writing;
  assign mem_be_o    = writing ? halfBe : 4'b0000;
  assign mem_wdata_o = (state_q == WRITE) ? {val_q, val_q} : '0;

  assign req_ready_o = (state_q == IDLE);
  assign eng_start_o = (state_q == START) || (state_q == WAIT);
  assign eng_saddr_o = start_q;
  assign eng_len_o   = len_q;

  assign done_o   = (state_q == DONE);
  assign err_o    = done_o && err_q;
  assign ok_o     = done_o && !err_q && (op_q || (val_q == 16'h0000));
  assign result_o = (done_o && !err_q) ? val_q : 16'h0000;

endmodule

// File: tb/tb_cksum_ctrl.sv
// Directed bench for cksum_ctrl with a behavioural checksum engine and packet memory;
// expected completions are queued at request time and matched when done_o pulses.
module tb_cksum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_op_i;
  logic [31:0] req_start_i;
  logic [31:0] req_len_i;
  logic [31:0] req_field_i;
  logic [31:0] mem_addr_o;
  logic [31:0] memRdata;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        eng_start_o;
  logic [31:0] eng_saddr_o;
  logic [31:0] eng_len_o;
  logic [31:0] engAddr;
  logic        engReady;
  logic [15:0] engVal;
  logic        done_o;
  logic        ok_o;
  logic        err_o;
  logic [15:0] result_o;

  cksum_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_start_i(req_start_i), .req_len_i(req_len_i), .req_field_i(req_field_i),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(memRdata), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .eng_start_o(eng_start_o), .eng_saddr_o(eng_saddr_o), .eng_len_o(eng_len_o),
    .eng_addr_i(engAddr), .eng_ready_i(engReady), .eng_val_i(engVal),
    .done_o(done_o), .ok_o(ok_o), .err_o(err_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Packet memory: registered read, byte-enabled write, plus a bench-side poke port.
  logic [31:0] tbMem [0:255];
  logic        pokeEn;
  logic [7:0]  pokeIdx;
  logic [31:0] pokeData;

  always @(posedge clk) begin
    memRdata <= tbMem[mem_addr_o[9:2]];
    if (pokeEn) tbMem[pokeIdx] <= pokeData;
    else if (mem_we_o) begin
      if (mem_be_o[3]) tbMem[mem_addr_o[9:2]][31:24] <= mem_wdata_o[31:24];
      if (mem_be_o[2]) tbMem[mem_addr_o[9:2]][23:16] <= mem_wdata_o[23:16];
      if (mem_be_o[1]) tbMem[mem_addr_o[9:2]][15:8]  <= mem_wdata_o[15:8];
      if (mem_be_o[0]) tbMem[mem_addr_o[9:2]][7:0]   <= mem_wdata_o[7:0];
    end
  end

  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 4; i++) t = {16'h0000, t[15:0]} + {16'h0000, t[31:16]};
    return t[15:0];
  endfunction

  // Engine model: one halfword address per cycle, data one cycle later, ready held until start drops.
  logic        engHang;
  int          engSt;
  logic [31:0] sAddrE, nHalf, issued, sumE, engCur;
  logic        pendValid, pendHalf;

  assign engCur = sAddrE + (issued << 1);

  always @(posedge clk) begin
    if (rst) begin
      engSt     <= 0;
      engReady  <= 1'b0;
      engVal    <= 16'h0000;
      engAddr   <= 32'h0;
      pendValid <= 1'b0;
    end else begin
      case (engSt)
        0: if (eng_start_o) begin
          sAddrE    <= eng_saddr_o;
          nHalf     <= eng_len_o >> 1;
          issued    <= 32'h0;
          sumE      <= 32'h0;
          pendValid <= 1'b0;
          engReady  <= 1'b0;
          engAddr   <= eng_saddr_o & ~32'h3;
          engSt     <= 1;
        end
        1: if (!eng_start_o) engSt <= 0;
        else if (!engHang) begin
          if (pendValid) sumE <= sumE + {16'h0000, (pendHalf ? memRdata[15:0] : memRdata[31:16])};
          if (issued < nHalf) begin
            pendValid <= 1'b1;
            pendHalf  <= engCur[1];
            issued    <= issued + 1;
            engAddr   <= (engCur + 32'd2) & ~32'h3;
          end else begin
            pendValid <= 1'b0;
            if (!pendValid) begin
              engVal   <= ~fold16(sumE);
              engReady <= 1'b1;
              engSt    <= 2;
            end
          end
        end
        default: if (!eng_start_o) engSt <= 0;
      endcase
    end
  end

  logic [31:0] wrAddrQ[$];
  logic [3:0]  wrBeQ[$];
  logic [31:0] wrDataQ[$];
  int          startCount = 0;

  always @(negedge clk) begin
    if (mem_we_o) begin
      wrAddrQ.push_back(mem_addr_o);
      wrBeQ.push_back(mem_be_o);
      wrDataQ.push_back(mem_wdata_o);
    end
    if (eng_start_o) startCount <= startCount + 1;
  end

  typedef struct {
    logic        ok;
    logic        err;
    logic [15:0] result;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pushExpect(input logic ok, input logic err, input logic [15:0] result);
    exp_t e;
    e.ok = ok;
    e.err = err;
    e.result = result;
    expQ.push_back(e);
  endtask

  task automatic pokeWord(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pokeEn = 1'b1;
    pokeIdx = idx;
    pokeData = data;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Leaves the bench at the first negedge after acceptance, with the request fields scrambled.
  task automatic applyStimulus(input logic op, input logic [31:0] start, input logic [31:0] len,
                               input logic [31:0] field);
    @(negedge clk);
    checkVal("acceptReady", {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_start_i = start;
    req_len_i   = len;
    req_field_i = field;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_op_i    = 1'($urandom);
    req_start_i = $urandom;
    req_len_i   = $urandom;
    req_field_i = $urandom;
    checkVal("busyReady", {31'h0, req_ready_o}, 32'h0);
  endtask

  task automatic checkOutput(input string tag, output int cycles);
    exp_t e;
    cycles = 1;
    while (done_o !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkVal({tag, "_done"}, {31'h0, done_o}, 32'h1);
    checkVal({tag, "_sbSize"}, expQ.size(), 32'h1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal({tag, "_ok"}, {31'h0, ok_o}, {31'h0, e.ok});
      checkVal({tag, "_err"}, {31'h0, err_o}, {31'h0, e.err});
      checkVal({tag, "_result"}, {16'h0, result_o}, {16'h0, e.result});
    end
  endtask

  initial begin
    int          updLat, verLat, lat, base, startBefore;
    logic [31:0] badLen[3];
    logic [31:0] badField[3];
    logic [31:0] hdr[5];

    hdr = '{32'h45000073, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
    badLen = '{32'd19, 32'd0, 32'd20};
    badField = '{32'h10A, 32'h10A, 32'h200};
    rst = 1'b1;
    engHang = 1'b0;
    pokeEn = 1'b0;
    pokeIdx = 8'h0;
    pokeData = 32'h0;
    req_valid_i = 1'b0;
    req_op_i = 1'b0;
    req_start_i = 32'h0;
    req_len_i = 32'h0;
    req_field_i = 32'h0;
    for (int i = 0; i < 5; i++) pokeWord(8'(64 + i), hdr[i]);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkVal("rstReady", {31'h0, req_ready_o}, 32'h1);
    checkVal("rstDone", {31'h0, done_o}, 32'h0);
    checkVal("rstStart", {31'h0, eng_start_o}, 32'h0);
    checkVal("rstWe", {31'h0, mem_we_o}, 32'h0);
    checkVal("rstAddr", mem_addr_o, 32'h0);
    checkVal("rstErrOk", {30'h0, err_o, ok_o}, 32'h0);
    checkVal("rstResult", {16'h0, result_o}, 32'h0);

    $display("[TB] update of IPv4 header at 0x100");
    base = wrAddrQ.size();
    pushExpect(1'b1, 1'b0, 16'hB861);
    applyStimulus(1'b1, 32'h100, 32'd20, 32'h10A);
    checkOutput("update", updLat);
    checkVal("updWrCount", wrAddrQ.size() - base, 32'd2);
    checkVal("clrAddr", wrAddrQ[base], 32'h108);
    checkVal("clrBe", {28'h0, wrBeQ[base]}, 32'h3);
    checkVal("clrData", wrDataQ[base], 32'h0);
    checkVal("wrAddr", wrAddrQ[base+1], 32'h108);
    checkVal("wrBe", {28'h0, wrBeQ[base+1]}, 32'h3);
    checkVal("wrData", wrDataQ[base+1], 32'hB861B861);
    checkVal("memWord", tbMem[66], 32'h4011B861);

    $display("[TB] verify of updated header");
    base = wrAddrQ.size();
    pushExpect(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 32'h100, 32'd20, 32'h10A);
    checkOutput("verify", verLat);
    checkVal("verWrCount", wrAddrQ.size() - base, 32'd0);
    checkVal("latDelta", updLat - verLat, 32'd2);

    $display("[TB] verify of corrupted header");
    pokeWord(8'd67, 32'hC1A80001);
    pushExpect(1'b0, 1'b0, 16'hFEFF);
    applyStimulus(1'b0, 32'h100, 32'd20, 32'h10A);
    checkOutput("corrupt", lat);
    pokeWord(8'd67, 32'hC0A80001);

    $display("[TB] malformed requests");
    for (int i = 0; i < 3; i++) begin
      base = wrAddrQ.size();
      startBefore = startCount;
      pushExpect(1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 32'h100, badLen[i], badField[i]);
      checkOutput($sformatf("bad%0d", i), lat);
      checkVal($sformatf("bad%0dLat", i), lat, 32'd2);
      checkVal($sformatf("bad%0dStart", i), startCount - startBefore, 32'd0);
      checkVal($sformatf("bad%0dWr", i), wrAddrQ.size() - base, 32'd0);
    end

    $display("[TB] engine timeout");
    engHang = 1'b1;
    base = wrAddrQ.size();
    startBefore = startCount;
    pushExpect(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 32'h100, 32'd20, 32'h10A);
    checkOutput("timeout", lat);
    checkVal("toStartLow", {31'h0, eng_start_o}, 32'h0);
    engHang = 1'b0;
    checkVal("toLat", lat, 32'd19);
    checkVal("toStartCycles", startCount - startBefore, 32'd17);
    checkVal("toWr", wrAddrQ.size() - base, 32'd0);

    $display("[TB] reset during update wait");
    base = wrAddrQ.size();
    applyStimulus(1'b1, 32'h100, 32'd20, 32'h10A);
    repeat (4) @(negedge clk);
    checkVal("inWait", {31'h0, eng_start_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkVal("abortReady", {31'h0, req_ready_o}, 32'h1);
    checkVal("abortStart", {31'h0, eng_start_o}, 32'h0);
    repeat (20) @(negedge clk);
    checkVal("abortWr", wrAddrQ.size() - base, 32'd1);
    checkVal("abortMem", tbMem[66], 32'h40110000);
    pushExpect(1'b0, 1'b0, 16'hB861);
    applyStimulus(1'b0, 32'h100, 32'd20, 32'h10A);
    checkOutput("postReset", lat);
    checkVal("sbDrained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
